// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fill_act_pkg.sv
// Shared types and constants for the active fill cell: FSM states, pattern modes
// and the Galois LFSR/MISR polynomial.
package gf180mcu_fd_sc_mcu7t5v0__fill_act_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        QUIET  = 2'b00,
        CHECK  = 2'b01,
        LFSR   = 2'b10,
        TOGGLE = 2'b11
    } mode_e;

    localparam int unsigned     LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fill_act_lfsr.sv
// 16-bit right-shifting Galois register with load and advance; with din tied to zero
// it is a plain LFSR, with data on din it acts as a MISR.
module gf180mcu_fd_sc_mcu7t5v0__fill_act_lfsr
    import gf180mcu_fd_sc_mcu7t5v0__fill_act_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    input  logic [LFSR_W-1:0] din,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] stepped;

    assign stepped = state[0] ? ({1'b0, state[LFSR_W-1:1]} ^ LFSR_TAPS)
                              :  {1'b0, state[LFSR_W-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (advance) begin
            state <= stepped ^ din;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__fill_act.sv
// Active fill cell: burst-sequenced switching pattern generator on WIDTH lanes.
// Optional MISR signature output enabled by GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN.
module gf180mcu_fd_sc_mcu7t5v0__fill_act
    import gf180mcu_fd_sc_mcu7t5v0__fill_act_pkg::*;
#(
    parameter int unsigned       WIDTH = 8,
    parameter int unsigned       CW    = 16,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [CW-1:0]    BURST,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
    ,
    output logic [15:0]      SIG
`endif
`ifdef USE_POWER_PINS
    ,
    inout  wire              VDD,
    inout  wire              VSS
`endif
);

    localparam logic [15:0] CHECK_PAT = 16'h5555;

    state_e            state, state_nxt;
    mode_e             mode_r, mode_sel;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              phase, phase_nxt;
    logic              start;
    logic [WIDTH-1:0]  pat, q_nxt;
    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr_hi;

    // Upper LFSR bits only feed the feedback path, never the lanes.
    assign unused_lfsr_hi = ^lfsr_state;

    // The LFSR runs one step ahead of Q: it sits at SEED outside RUN, so the start
    // edge shows SEED while the register moves on to the next value.
    gf180mcu_fd_sc_mcu7t5v0__fill_act_lfsr #(
        .RESET_VAL(SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RN      (RN),
        .load    (state_nxt != RUN),
        .load_val(SEED),
        .advance (state_nxt == RUN),
        .din     ('0),
        .state   (lfsr_state)
    );

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        start     = (state == IDLE) && EN && START;
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = gf180mcu_fd_sc_mcu7t5v0__fill_act_pkg::DONE;
            default: state_nxt = IDLE;
        endcase
        if (!EN) state_nxt = IDLE;

        cnt_nxt = cnt;
        if (start)                 cnt_nxt = BURST;
        else if (state_nxt != RUN) cnt_nxt = '0;
        else if (cnt != '0)        cnt_nxt = cnt - CW'(1);

        mode_sel  = start ? mode_e'(MODE) : mode_r;
        phase_nxt = start ? 1'b0 : ~phase;

        pat = '0;
        case (mode_sel)
            CHECK:   pat = phase_nxt ? ~CHECK_PAT[WIDTH-1:0] : CHECK_PAT[WIDTH-1:0];
            LFSR:    pat = lfsr_state[WIDTH-1:0];
            TOGGLE:  pat = phase_nxt ? '0 : '1;
            default: pat = '0;
        endcase
        q_nxt = (state_nxt == RUN) ? pat : '0;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            mode_r <= QUIET;
            cnt    <= '0;
            phase  <= 1'b0;
            Q      <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            phase  <= phase_nxt;
            Q      <= q_nxt;
            BUSY   <= (state_nxt == RUN);
            DONE   <= (state_nxt == gf180mcu_fd_sc_mcu7t5v0__fill_act_pkg::DONE);
            if (start) mode_r <= mode_e'(MODE);
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
    // Signature absorbs each pattern shown on Q during RUN; cleared by START.
    gf180mcu_fd_sc_mcu7t5v0__fill_act_lfsr #(
        .RESET_VAL('0)
    ) u_misr (
        .CLK     (CLK),
        .RN      (RN),
        .load    (start),
        .load_val('0),
        .advance (state == RUN),
        .din     (LFSR_W'(Q)),
        .state   (SIG)
    );
`endif

    specify
    endspecify

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__fill_act.sv
// Directed self-checking bench for the active fill cell (WIDTH=8, CW=16, SEED=ACE1).
module tb_gf180mcu_fd_sc_mcu7t5v0__fill_act;

    logic        clk = 1'b0;
    logic        rn;
    logic        en;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] burst;
    logic [7:0]  q;
    logic        busy;
    logic        done;
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
    logic [15:0] sig;
`endif
`ifdef USE_POWER_PINS
    wire vdd = 1'b1;
    wire vss = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__fill_act #(
        .WIDTH(8),
        .CW   (16),
        .SEED (16'hACE1)
    ) dut (
        .CLK  (clk),
        .RN   (rn),
        .EN   (en),
        .START(start),
        .MODE (mode),
        .BURST(burst),
        .Q    (q),
        .BUSY (busy),
        .DONE (done)
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
        ,
        .SIG  (sig)
`endif
`ifdef USE_POWER_PINS
        ,
        .VDD  (vdd),
        .VSS  (vss)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check({tag, ".q"},    32'(q),    32'(eq));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic launch(input logic [1:0] m, input logic [15:0] b);
        mode  = m;
        burst = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] chk_seq [3] = '{8'h55, 8'hAA, 8'h55};
    logic [7:0] tog_seq [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};

    initial begin
        rn = 1'b0; en = 1'b0; start = 1'b0; mode = 2'b00; burst = '0;
        #12;
        check_out("reset", 8'h00, 1'b0, 1'b0);
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
        check("reset.sig", 32'(sig), 32'h0);
`endif
        rn = 1'b1;
        en = 1'b1;
        tick();

        // Checkerboard, BURST=3
        launch(2'b01, 16'd3);
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("chk%0d", i), chk_seq[i], 1'b1, 1'b0);
            tick();
        end
        check_out("chk_done", 8'h00, 1'b0, 1'b1);
        tick();
        check_out("chk_idle", 8'h00, 1'b0, 1'b0);

        // LFSR, BURST=2
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
        check("sig_hold", 32'(sig), 32'h0);
`endif
        launch(2'b10, 16'd2);
        check_out("lfsr0", 8'hE1, 1'b1, 1'b0);
        tick();
        check_out("lfsr1", 8'h70, 1'b1, 1'b0);
        tick();
        check_out("lfsr_done", 8'h00, 1'b0, 1'b1);
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
        check("lfsr_sig", 32'(sig), 32'hB400);
`endif
        tick();

        // All-toggle continuous, aborted by EN=0
        launch(2'b11, 16'd0);
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("tog%0d", i), tog_seq[i], 1'b1, 1'b0);
            tick();
        end
        en = 1'b0;
        tick();
        check_out("abort", 8'h00, 1'b0, 1'b0);
        tick();
        check_out("abort_nodone", 8'h00, 1'b0, 1'b0);

        // EN low with START in IDLE stays idle
        start = 1'b1;
        tick();
        check_out("en_low_start", 8'h00, 1'b0, 1'b0);
        en = 1'b1;

        // START held through RUN and DONE: one burst, then a fresh one from IDLE
        mode = 2'b10; burst = 16'd2;
        tick();
        check_out("hold0", 8'hE1, 1'b1, 1'b0);
        tick();
        check_out("hold1", 8'h70, 1'b1, 1'b0);
        tick();
        check_out("hold_done", 8'h00, 1'b0, 1'b1);
        tick();
        check_out("hold_idle", 8'h00, 1'b0, 1'b0);
        tick();
        check_out("hold_restart", 8'hE1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        check_out("hold_restart1", 8'h70, 1'b1, 1'b0);
        tick();
        tick();

        // BURST=1: single pattern then DONE
        launch(2'b01, 16'd1);
        check_out("b1_pat", 8'h55, 1'b1, 1'b0);
        tick();
        check_out("b1_done", 8'h00, 1'b0, 1'b1);
        tick();

        // Quiet window of 4 cycles
        launch(2'b00, 16'd4);
        for (int i = 0; i < 4; i++) begin
            check_out($sformatf("quiet%0d", i), 8'h00, 1'b1, 1'b0);
            tick();
        end
        check_out("quiet_done", 8'h00, 1'b0, 1'b1);
        tick();

        // MODE/BURST changes mid-burst are ignored
        launch(2'b01, 16'd3);
        mode = 2'b11; burst = 16'd1;
        tick();
        check_out("midchg1", 8'hAA, 1'b1, 1'b0);
        tick();
        check_out("midchg2", 8'h55, 1'b1, 1'b0);
        tick();
        check_out("midchg_done", 8'h00, 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-burst, checked between edges
        launch(2'b11, 16'd0);
        tick();
        check_out("pre_rst", 8'h00, 1'b1, 1'b0);
        #2;
        rn = 1'b0;
        #1;
        check_out("async_rst", 8'h00, 1'b0, 1'b0);
`ifdef GF180MCU_FD_SC_MCU7T5V0__FILL_ACT_SIG_EN
        check("async_rst.sig", 32'(sig), 32'h0);
`endif
        tick();
        rn = 1'b1;
        tick();
        check_out("post_rst", 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
